// File: rtl/sys_array_pkg.sv
// Shared types and defaults for the systolic array tile sequencer.
package sys_array_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_W,
    COMPUTE,
    DRAIN
  } state_t;

  localparam int SYS_ROW_DEF     = 16;
  localparam int SYS_COL_DEF     = 16;
  localparam int DATA_WIDTH_DEF  = 16;
  localparam int DRAIN_SLACK_DEF = 4;

  // Worst-case cycles from DRAIN entry until the last result leaves the array.
  function automatic int drain_limit(input int rows, input int cols, input int slack);
    return rows + cols + slack;
  endfunction

endpackage

// File: rtl/act_skew.sv
// Triangular input skew: row i sees the activation vector i cycles late.
// Row 0 is a combinational pass-through; invalid cycles shift in zero.
module act_skew #(
  parameter int SYS_ROW    = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] data   [SYS_ROW],
  output logic [DATA_WIDTH-1:0] skewed [SYS_ROW]
);

  genvar gi;
  generate
    for (gi = 0; gi < SYS_ROW; gi++) begin : g_row
      logic [DATA_WIDTH-1:0] head;
      assign head = valid ? data[gi] : '0;

      if (gi == 0) begin : g_pass
        assign skewed[gi] = head;
      end else begin : g_dly
        logic [DATA_WIDTH-1:0] pipe_reg [gi];

        always_ff @(posedge clk or negedge rstn) begin
          if (!rstn) begin
            for (int k = 0; k < gi; k++) pipe_reg[k] <= '0;
          end else begin
            pipe_reg[0] <= head;
            for (int k = 1; k < gi; k++) pipe_reg[k] <= pipe_reg[k-1];
          end
        end

        assign skewed[gi] = pipe_reg[gi-1];
      end
    end
  endgenerate

endmodule

// File: rtl/sys_array_ctrl.sv
// Tile sequencer for the weight-stationary systolic array: loads weights,
// streams skewed activations, then counts results out of the last column.
module sys_array_ctrl
  import sys_array_pkg::*;
#(
  parameter int SYS_ROW     = SYS_ROW_DEF,
  parameter int SYS_COL     = SYS_COL_DEF,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH   = 16,
  parameter int ADDR_WIDTH  = 10,
  parameter int DRAIN_SLACK = DRAIN_SLACK_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  skip_wload,
  input  logic [CNT_WIDTH-1:0]  num_vec,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  w_rd_en,
  output logic [ADDR_WIDTH-1:0] w_rd_addr,
  input  logic [DATA_WIDTH-1:0] w_rd_data [SYS_COL],
  output logic                  a_rd_en,
  output logic [ADDR_WIDTH-1:0] a_rd_addr,
  input  logic [DATA_WIDTH-1:0] a_rd_data [SYS_ROW],
  output logic                  arr_en,
  output logic [SYS_COL-1:0]    arr_w_wen,
  output logic [DATA_WIDTH-1:0] arr_w_in [SYS_COL],
  output logic [DATA_WIDTH-1:0] arr_in   [SYS_ROW],
  input  logic [SYS_COL-1:0]    arr_en_out
);

  localparam logic [CNT_WIDTH-1:0] ROW_LAST    = CNT_WIDTH'(SYS_ROW - 1);
  localparam logic [CNT_WIDTH-1:0] DRAIN_LIMIT = CNT_WIDTH'(drain_limit(SYS_ROW, SYS_COL, DRAIN_SLACK));
  localparam logic [CNT_WIDTH-1:0] ONE         = CNT_WIDTH'(1);

  state_t               state_reg,   state_next;
  logic [CNT_WIDTH-1:0] cnt_reg,     cnt_next;
  logic [CNT_WIDTH-1:0] num_vec_reg, num_vec_next;
  logic [CNT_WIDTH-1:0] res_cnt_reg, res_cnt_next;
  logic                 w_valid_reg, a_valid_reg;
  logic                 res_pulse;
  logic                 unused_en_out;

  // Only the last column's en_out marks a finished result vector.
  assign unused_en_out = ^arr_en_out[SYS_COL-2:0];
  assign res_pulse     = (state_reg != IDLE) && arr_en_out[SYS_COL-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      num_vec_reg <= '0;
      res_cnt_reg <= '0;
      w_valid_reg <= 1'b0;
      a_valid_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      num_vec_reg <= num_vec_next;
      res_cnt_reg <= res_cnt_next;
      w_valid_reg <= w_rd_en;
      a_valid_reg <= a_rd_en;
    end
  end

  // cnt_reg indexes weight rows, then activation vectors, then drain cycles.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    num_vec_next = num_vec_reg;
    res_cnt_next = res_cnt_reg + {{(CNT_WIDTH-1){1'b0}}, res_pulse};
    w_rd_en      = 1'b0;
    a_rd_en      = 1'b0;
    done         = 1'b0;
    err          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start && (num_vec != '0)) begin
          num_vec_next = num_vec;
          cnt_next     = '0;
          res_cnt_next = '0;
          state_next   = skip_wload ? COMPUTE : LOAD_W;
        end
      end
      LOAD_W: begin
        w_rd_en  = 1'b1;
        cnt_next = cnt_reg + ONE;
        if (cnt_reg == ROW_LAST) begin
          cnt_next   = '0;
          state_next = COMPUTE;
        end
      end
      COMPUTE: begin
        a_rd_en  = 1'b1;
        cnt_next = cnt_reg + ONE;
        if (cnt_reg == num_vec_reg - ONE) begin
          cnt_next   = '0;
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        cnt_next = cnt_reg + ONE;
        // A result arriving on the timeout cycle still counts as completion.
        if (res_cnt_next == num_vec_reg) begin
          done       = 1'b1;
          state_next = IDLE;
        end else if (cnt_reg == DRAIN_LIMIT) begin
          done       = 1'b1;
          err        = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy      = (state_reg != IDLE);
  assign w_rd_addr = (state_reg == LOAD_W)  ? cnt_reg[ADDR_WIDTH-1:0] : '0;
  assign a_rd_addr = (state_reg == COMPUTE) ? cnt_reg[ADDR_WIDTH-1:0] : '0;
  assign arr_en    = a_valid_reg;
  assign arr_w_wen = {SYS_COL{w_valid_reg}};

  genvar gi;
  generate
    for (gi = 0; gi < SYS_COL; gi++) begin : g_w_in
      assign arr_w_in[gi] = w_valid_reg ? w_rd_data[gi] : '0;
    end
  endgenerate

  act_skew #(
    .SYS_ROW   (SYS_ROW),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_act_skew (
    .clk   (clk),
    .rstn  (rstn),
    .valid (a_valid_reg),
    .data  (a_rd_data),
    .skewed(arr_in)
  );

endmodule

// File: tb/tb_sys_array_ctrl.sv
// Randomized bench for sys_array_ctrl against a tile-schedule reference model.
module tb_sys_array_ctrl;

  localparam int R     = 16;
  localparam int C     = 16;
  localparam int DW    = 16;
  localparam int CW    = 16;
  localparam int AW    = 10;
  localparam int LIMIT = 16 + 16 + 4;
  localparam int MAXC  = 20000;
  localparam int AMEM  = 64;

  typedef logic [DW-1:0] vec_t [16];

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          skip_wload = 1'b0;
  logic [CW-1:0] num_vec = '0;
  logic          busy, done, err;
  logic          w_rd_en, a_rd_en, arr_en;
  logic [AW-1:0] w_rd_addr, a_rd_addr;
  logic [DW-1:0] w_rd_data [C];
  logic [DW-1:0] a_rd_data [R];
  logic [C-1:0]  arr_w_wen;
  logic [DW-1:0] arr_w_in [C];
  logic [DW-1:0] arr_in   [R];
  logic [C-1:0]  arr_en_out = '0;

  always #5 clk = ~clk;

  sys_array_ctrl dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .skip_wload(skip_wload),
    .num_vec   (num_vec),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .w_rd_en   (w_rd_en),
    .w_rd_addr (w_rd_addr),
    .w_rd_data (w_rd_data),
    .a_rd_en   (a_rd_en),
    .a_rd_addr (a_rd_addr),
    .a_rd_data (a_rd_data),
    .arr_en    (arr_en),
    .arr_w_wen (arr_w_wen),
    .arr_w_in  (arr_w_in),
    .arr_in    (arr_in),
    .arr_en_out(arr_en_out)
  );

  logic [DW-1:0] wmem [R][C];
  logic [DW-1:0] amem [AMEM][R];
  bit            hist_valid [MAXC];
  int            hist_idx   [MAXC];
  bit            pulse_at   [MAXC];

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  // Reference model: one outstanding tile, described by its start cycle.
  bit m_active = 1'b0;
  bit m_skip;
  int m_s, m_nv, m_cnt;

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [255:0] pack(input vec_t v);
    logic [255:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[k*DW +: DW] = v[k];
    return r;
  endfunction

  task automatic do_cycle(input bit st, input int nv, input bit sk, input bit rst);
    logic pw, pa;
    logic [AW-1:0] pwa, paa;
    bit idle_now, e_busy, e_wen, e_wv, e_aen, e_en, e_done, e_err;
    int e_waddr, e_aaddr, c0, d0, rel, idx;
    vec_t e_win, e_in;

    pw  = (w_rd_en === 1'b1);
    pwa = w_rd_addr;
    pa  = (a_rd_en === 1'b1);
    paa = a_rd_addr;
    @(posedge clk);
    #1;
    cyc++;

    // Buffer models: registered read, garbage when not read.
    for (int c = 0; c < C; c++) w_rd_data[c] = (pw && pwa < R) ? wmem[pwa][c] : DW'($urandom);
    for (int r = 0; r < R; r++) a_rd_data[r] = (pa && paa < AMEM) ? amem[paa][r] : DW'($urandom);
    rstn       = !rst;
    start      = st;
    num_vec    = CW'(nv);
    skip_wload = sk;
    arr_en_out = C'($urandom);
    arr_en_out[C-1] = 1'b0;
    if (pulse_at[cyc]) arr_en_out[C-1] = 1'b1;
    else if (!m_active && $urandom_range(3) == 0) arr_en_out[C-1] = 1'b1;

    if (rst) begin
      m_active = 1'b0;
      for (int k = 0; k < R; k++) if (cyc - k >= 0) hist_valid[cyc-k] = 1'b0;
    end
    idle_now = !m_active;
    {e_busy, e_wen, e_wv, e_aen, e_en, e_done, e_err} = '0;
    e_waddr = 0;
    e_aaddr = 0;
    for (int k = 0; k < 16; k++) e_win[k] = '0;

    if (m_active) begin
      rel = cyc - m_s;
      c0  = m_s + 1 + (m_skip ? 0 : R);
      d0  = c0 + m_nv;
      e_busy = 1'b1;
      if (!m_skip && rel >= 1 && rel <= R) begin
        e_wen = 1'b1;
        e_waddr = rel - 1;
      end
      if (!m_skip && rel >= 2 && rel <= R + 1) begin
        e_wv = 1'b1;
        for (int k = 0; k < C; k++) e_win[k] = wmem[rel-2][k];
      end
      if (cyc >= c0 && cyc < d0) begin
        e_aen = 1'b1;
        e_aaddr = (cyc - c0) % (1 << AW);
      end
      if (cyc > c0 && cyc <= d0) begin
        e_en = 1'b1;
        hist_valid[cyc] = 1'b1;
        hist_idx[cyc] = cyc - c0 - 1;
      end
      if (arr_en_out[C-1]) m_cnt++;
      if (cyc >= d0 && (m_cnt == m_nv || cyc == d0 + LIMIT)) begin
        e_done = 1'b1;
        e_err = (m_cnt != m_nv);
        m_active = 1'b0;
        $display("tile start=%0d nv=%0d skip=%0d end=%0d err=%0d", m_s, m_nv, m_skip, cyc, e_err);
      end
    end
    if (idle_now && !rst && st && nv != 0) begin
      m_active = 1'b1;
      m_s = cyc;
      m_nv = nv;
      m_skip = sk;
      m_cnt = 0;
    end

    for (int i = 0; i < 16; i++) begin
      idx = cyc - i;
      e_in[i] = (idx >= 0 && hist_valid[idx]) ? amem[hist_idx[idx]][i] : '0;
    end

    #1;
    check_eq("busy", busy, e_busy);
    check_eq("done", done, e_done);
    check_eq("err", err, e_err);
    check_eq("w_rd_en", w_rd_en, e_wen);
    if (e_wen || rst) check_eq("w_rd_addr", w_rd_addr, e_waddr);
    check_eq("arr_w_wen", arr_w_wen, {C{e_wv}});
    if (e_wv || rst) check_eq("arr_w_in", pack(arr_w_in), pack(e_win));
    check_eq("a_rd_en", a_rd_en, e_aen);
    if (e_aen || rst) check_eq("a_rd_addr", a_rd_addr, e_aaddr);
    check_eq("arr_en", arr_en, e_en);
    check_eq("arr_in", pack(arr_in), pack(e_in));
  endtask

  // mode 0: all results arrive; 1: one result missing; 2: last result on the timeout cycle.
  task automatic run_tile(input int nv, input bit sk, input int mode);
    int s, c0, d0, np, lo, hi, p;
    s  = cyc + 1;
    c0 = s + 1 + (sk ? 0 : R);
    d0 = c0 + nv;
    np = (mode == 0) ? nv : nv - 1;
    lo = c0 + 1;
    hi = d0 + LIMIT - 1;
    for (int k = 0; k < np; k++) begin
      p = $urandom_range(hi, lo);
      while (pulse_at[p]) p = $urandom_range(hi, lo);
      pulse_at[p] = 1'b1;
    end
    if (mode == 2) pulse_at[d0 + LIMIT] = 1'b1;
    do_cycle(1'b1, nv, sk, 1'b0);
    for (int k = 0; k < 400 && m_active; k++)
      do_cycle($urandom_range(7) == 0, $urandom_range(5, 1), 1'($urandom_range(1)), 1'b0);
  endtask

  initial begin
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) wmem[r][c] = DW'($urandom);
    for (int a = 0; a < AMEM; a++)
      for (int r = 0; r < R; r++) amem[a][r] = DW'($urandom);
    for (int r = 0; r < R; r++) amem[0][r] = DW'(r + 1);
    for (int c = 0; c < C; c++) w_rd_data[c] = '0;
    for (int r = 0; r < R; r++) a_rd_data[r] = '0;

    repeat (3) do_cycle(1'b0, 0, 1'b0, 1'b1);
    do_cycle(1'b0, 0, 1'b0, 1'b0);

    // Abort in the middle of weight loading.
    do_cycle(1'b1, 4, 1'b0, 1'b0);
    repeat (4) do_cycle(1'b0, 0, 1'b0, 1'b0);
    repeat (2) do_cycle(1'b0, 0, 1'b0, 1'b1);
    repeat (2) do_cycle(1'b0, 0, 1'b0, 1'b0);

    run_tile(4, 1'b0, 0);
    run_tile(1, 1'b1, 0);
    do_cycle(1'b1, 0, 1'b0, 1'b0);
    do_cycle(1'b1, 0, 1'b1, 1'b0);
    do_cycle(1'b0, 0, 1'b0, 1'b0);
    run_tile(3, 1'b0, 1);
    run_tile(2, 1'b1, 2);
    run_tile(1, 1'b1, 1);

    for (int t = 0; t < 25; t++) begin
      repeat ($urandom_range(2)) do_cycle($urandom_range(1) == 1, 0, 1'b0, 1'b0);
      run_tile($urandom_range(12, 1), 1'($urandom_range(1)), $urandom_range(2));
    end
    repeat (R + 2) do_cycle(1'b0, 0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sys_array_ctrl.md
Name: sys_array_ctrl

Overview:
Sequencer for one systolic matrix-multiply tile on the weight-stationary systolic array.
- On start, streams SYS_ROW weight rows from the weight buffer into the array.
- Streams num_vec activation vectors from the activation buffer, skewed per row.
- Counts result vectors leaving the array's last column, then signals done.
- Sits between the MMU command front-end and the array's in/w_in/w_wen/en ports.

Parameters:
SYS_ROW, 16, array rows; activation vector length.
SYS_COL, 16, array columns; weight row length.
DATA_WIDTH, 16, operand width.
CNT_WIDTH, 16, width of num_vec and internal vector counters.
ADDR_WIDTH, 10, buffer address width; must satisfy 2^ADDR_WIDTH >= max(SYS_ROW, num_vec).
DRAIN_SLACK, 4, extra drain cycles before timeout.

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
start  in  1  begin tile; sampled only in IDLE
skip_wload  in  1  reuse resident weights; sampled with start
num_vec  in  CNT_WIDTH  activation vectors in tile; sampled with start
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse at tile end
err  out  1  one-cycle pulse with done on drain timeout
w_rd_en  out  1  weight buffer read strobe
w_rd_addr  out  ADDR_WIDTH  weight buffer address
w_rd_data  in  DATA_WIDTH x SYS_COL (unpacked)  weight row; valid 1 cycle after w_rd_en
a_rd_en  out  1  activation buffer read strobe
a_rd_addr  out  ADDR_WIDTH  activation buffer address
a_rd_data  in  DATA_WIDTH x SYS_ROW (unpacked)  activation vector; valid 1 cycle after a_rd_en
arr_en  out  1  to array en
arr_w_wen  out  SYS_COL  to array w_wen
arr_w_in  out  DATA_WIDTH x SYS_COL  to array w_in
arr_in  out  DATA_WIDTH x SYS_ROW  to array in (skewed)
arr_en_out  in  SYS_COL  from array en_out

Behaviour:
- Reset: all outputs 0, arr_in / arr_w_in 0, state IDLE, all counters 0, skew registers 0.
- Reset asserted mid-tile aborts immediately with no done pulse.
- States: IDLE, LOAD_W, COMPUTE, DRAIN.
- IDLE:
  - start=1 and num_vec==0: ignored; stay IDLE.
  - start=1 and num_vec!=0: latch num_vec. Next state is LOAD_W, or COMPUTE if skip_wload=1.
  - start outside IDLE is ignored.
- LOAD_W: exactly SYS_ROW cycles.
  - w_rd_en=1; w_rd_addr=0..SYS_ROW-1.
  - Address a holds the weights destined for array row SYS_ROW-1-a.
  - One cycle after each read: arr_w_in=w_rd_data and arr_w_wen=all ones, else arr_w_wen=0.
  - After the last read, go to COMPUTE.
- COMPUTE: exactly num_vec cycles.
  - a_rd_en=1; a_rd_addr=0..num_vec-1, wrapping modulo 2^ADDR_WIDTH.
  - One cycle after each read: arr_en=1 and a_rd_data enters the skew stage.
  - The first activation read immediately follows the last weight read. No bubble is required, because en trails w_wen through the array at the same per-row rate.
  - After the last read, go to DRAIN.
- Skew: arr_in[i] is a_rd_data[i] delayed by i registers; row 0 is combinational from the read data.
  - When no vector is valid, zero is shifted in.
- Result counting:
  - res_cnt increments on every cycle with arr_en_out[SYS_COL-1]=1, in any non-IDLE state.
  - res_cnt clears on leaving IDLE.
- DRAIN:
  - When res_cnt==num_vec: done=1 for one cycle, then IDLE.
  - Drain timer runs from DRAIN entry. Reaching SYS_ROW+SYS_COL+DRAIN_SLACK without completion gives done=1 and err=1, then IDLE.
  - If the final en_out pulse and the timeout land in the same cycle, completion wins (err=0).
- busy falls the cycle after done.
- All counters are CNT_WIDTH wide, unsigned, with no saturation.

Decomposition:
- Package sys_array_pkg holds:
  - the state enum (IDLE, LOAD_W, COMPUTE, DRAIN);
  - default SYS_ROW, SYS_COL, DATA_WIDTH;
  - the DRAIN_SLACK default;
  - a function giving the drain limit.
- Sub-module act_skew (SYS_ROW, DATA_WIDTH) holds the triangular delay registers, with inputs valid and data.

Test Plan:
- Reset mid-LOAD_W (cycle 5) -> all outputs 0 next cycle; busy=0; no done.
- start, num_vec=4, skip_wload=0 -> w_rd_en for 16 cycles at addr 0..15; arr_w_wen=FFFF for 16 cycles lagging by 1; a_rd_en for 4 cycles at addr 0..3; arr_en 4 cycles. Model en_out[15] at 4 pulses -> single done, err=0.
- Skew check: a_rd_data row i = i+1 for vector 0 -> arr_in[i] shows i+1 exactly i cycles after arr_en rises.
- skip_wload=1, num_vec=1 -> no w_rd_en, a_rd_en starts the cycle after start, done after 1 en_out pulse.
- start with num_vec=0, and start while busy -> both ignored: busy unchanged, no extra reads, one done per accepted tile.
- en_out held low after COMPUTE -> done=1 and err=1 exactly 36 cycles after DRAIN entry (16+16+4); final pulse on cycle 36 -> err=0.
